io_debounce: RTL
================

IO_DEBOUNCE -- requirements
Module: io_debounce

Interface
REQ-001 Parameter WIDTH, default 12: number of independent input channels (KEY[1:0] plus SW[9:0] on the board).
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: number of consecutive stable cycles required to accept a new level (10 ms at 50 MHz); legal range 1..2^20.
REQ-003 Parameter INVERT_MASK, default 12'b000000000011: per-channel raw polarity; a set bit marks an active-low input such as KEY.
REQ-004 Port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 Port raw_in, input, WIDTH bits: asynchronous pin levels.
REQ-007 Port ev_clr, input, WIDTH bits: per-channel clear for the sticky event flags.
REQ-008 Port level, output, WIDTH bits: debounced logical level, where 1 means pressed or on.
REQ-009 Port press_pulse, output, WIDTH bits: one-cycle strobe on each accepted 0->1 transition.
REQ-010 Port release_pulse, output, WIDTH bits: one-cycle strobe on each accepted 1->0 transition.
REQ-011 Port ev_sticky, output, WIDTH bits: latched press events, present only when IO_DEBOUNCE_STICKY_EN is defined.

Function
REQ-012 Each channel SHALL pass raw_in XOR INVERT_MASK through a 2-flop synchronizer before any other logic.
REQ-013 Each channel SHALL implement a 4-state FSM with states S_LO, S_WAIT_HI, S_HI and S_WAIT_LO.
REQ-014 FSM transitions from S_LO and S_HI: S_LO moves to S_WAIT_HI when the synchronized input is 1; S_HI moves to S_WAIT_LO when it is 0; in both cases the counter is cleared.
REQ-015 FSM transitions from the wait states: a wait state increments a 20-bit counter while the input holds the new value; it returns to the previous stable state, with the counter cleared, if the input reverts for even one cycle.
REQ-016 Acceptance timing: when the counter reaches DEBOUNCE_CYCLES-1 with the input still at the new value, the FSM SHALL enter the new stable state on the next edge.
REQ-017 On acceptance, level SHALL update and the matching pulse SHALL assert in that same cycle.
REQ-018 Latency: a clean input step SHALL appear on level exactly 2+DEBOUNCE_CYCLES clock edges after the first edge that samples the new raw value.
REQ-019 Each pulse SHALL be exactly one cycle wide; press_pulse and release_pulse of one channel SHALL never assert together.
REQ-020 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each be accepted on their own schedule.
REQ-021 The counter SHALL never wrap around: it saturates at DEBOUNCE_CYCLES-1 and is used only inside the wait states.
REQ-022 Glitches shorter than DEBOUNCE_CYCLES cycles SHALL produce no change on level and no pulse.

Reset
REQ-023 While rst is high, all outputs SHALL be held at the values in REQ-024, asynchronously.
REQ-024 Reset values: synchronizer flops hold logical 0 (raw value equal to INVERT_MASK), FSMs are in S_LO, counters are 0, and level, press_pulse, release_pulse and ev_sticky are all 0.
REQ-025 A reset asserted during a wait state SHALL abandon the pending transition with no pulse emitted.
REQ-026 After reset is released, an input already held high SHALL be accepted as a normal press, with latency per REQ-018.

Configuration
REQ-027 When the macro IO_DEBOUNCE_STICKY_EN is defined, ev_sticky[i] SHALL set on press_pulse[i] and clear on ev_clr[i].
REQ-028 If press_pulse[i] and ev_clr[i] occur in the same cycle, the flag SHALL be set (set wins).
REQ-029 When IO_DEBOUNCE_STICKY_EN is undefined, the ev_sticky port and its flops SHALL be absent and ev_clr SHALL be ignored.

Structure
REQ-030 A shared package or header io_pkg SHALL hold the FSM state encoding, the counter width constant (20), and the default DEBOUNCE_CYCLES and INVERT_MASK values.
REQ-031 The per-channel synchronizer, FSM and counter SHALL be a sub-module io_debounce_ch, instantiated WIDTH times by a generate loop; the sticky logic stays at the top level.
REQ-032 The block SHALL sit between the board pins and io_bus, so that io_bus consumes level and ev_sticky in place of the raw SW/KEY signals.

Verification (bench uses DEBOUNCE_CYCLES=4, WIDTH=12)
REQ-033 Step test: drive raw_in[0] from 1 to 0 (active-low KEY) and hold -> level[0] rises exactly 6 edges later, with press_pulse[0] high for that single cycle.
REQ-034 Glitch rejection: pulse raw_in[5] high for 3 cycles, then low -> level[5], press_pulse[5] and release_pulse[5] stay 0 throughout.
REQ-035 Bounce test: drive the pattern 1,0,1,1,1,1,1 on SW channel 3 -> exactly one press_pulse[3], 6 edges after the final rising sample.
REQ-036 Sticky flag: press channel 2, then assert ev_clr[2] in the same cycle as a second press_pulse[2] -> ev_sticky[2] remains 1; a later lone ev_clr[2] clears it to 0.
REQ-037 Reset in a wait state: assert rst 2 cycles into S_WAIT_HI -> all outputs go to 0 immediately; after release with the input still held, the press is accepted 6 edges later.
REQ-038 Independent channels: step raw_in[9:6] to 4'b1111 in one cycle -> four simultaneous press_pulse bits and no cross-channel effects.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the board input debouncer: state encoding, counter width, defaults.
// Latency: n/a (package).
// Backpressure: n/a (package).
package io_pkg;

    // Per-channel debounce FSM states
    typedef enum logic [1:0] {
        S_LO      = 2'd0,
        S_WAIT_HI = 2'd1,
        S_HI      = 2'd2,
        S_WAIT_LO = 2'd3
    } deb_state_t;

    localparam int          CNT_W               = 20;
    localparam int          DEF_WIDTH           = 12;
    localparam int          DEF_DEBOUNCE_CYCLES = 500000;
    // KEY[1:0] are active-low on the board; SW[9:0] are active-high
    localparam logic [11:0] DEF_INVERT_MASK     = 12'b000000000011;

    // The debounced level is high in S_HI and while a release is still pending
    function automatic logic state_is_high(deb_state_t s);
        return (s == S_HI) || (s == S_WAIT_LO);
    endfunction

endpackage

// File: rtl/io_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, 4-state FSM and saturating stable-cycle counter.
// Latency: a clean step reaches level 2+DEBOUNCE_CYCLES edges after the first edge sampling it.
// Backpressure: none; the channel free-runs and pulses cannot be stalled.
//
// Ports: clk, rst (async active-high), raw (pin level), level (debounced, 1 = on),
//        press_pulse / release_pulse (one-cycle strobes on accepted transitions).
module io_debounce_ch
    import io_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic INVERT          = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             sync_in;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_d, release_d;

    // Polarity is fixed before synchronizing so reset (0) means "released" for every pin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw ^ INVERT};
        end
    end

    assign sync_in = sync_q[1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            S_LO: begin
                if (sync_in) begin
                    state_d = S_WAIT_HI;
                    cnt_d   = '0;
                end
            end
            S_WAIT_HI: begin
                if (!sync_in) begin
                    state_d = S_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = S_HI;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HI: begin
                if (!sync_in) begin
                    state_d = S_WAIT_LO;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LO: begin
                if (sync_in) begin
                    state_d = S_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = S_LO;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_LO;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_LO;
            cnt_q         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

    // Decoded from the state flop, so it changes on the same edge as the pulse
    assign level = state_is_high(state_q);

endmodule

// File: rtl/io_debounce.sv
// Debounces the board KEY/SW pins into clean levels, press/release strobes and optional sticky press flags.
// Latency: level/pulses follow a clean step by 2+DEBOUNCE_CYCLES edges; ev_sticky one edge after press_pulse.
// Backpressure: none; events are never stalled, sticky flags hold presses until ev_clr.
//
// Ports: clk, rst (async active-high), raw_in (pins), ev_clr (sticky clear), level,
//        press_pulse, release_pulse, ev_sticky (only with IO_DEBOUNCE_STICKY_EN defined).
// Feeds io_bus, which consumes level and ev_sticky instead of the raw pins.
module io_debounce
    import io_pkg::*;
#(
    parameter int               WIDTH           = DEF_WIDTH,
    parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [WIDTH-1:0] INVERT_MASK     = WIDTH'(DEF_INVERT_MASK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    input  logic [WIDTH-1:0] ev_clr,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
`ifdef IO_DEBOUNCE_STICKY_EN
    ,
    output logic [WIDTH-1:0] ev_sticky
`endif
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        io_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (INVERT_MASK[i])
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .raw           (raw_in[i]),
            .level         (level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

`ifdef IO_DEBOUNCE_STICKY_EN
    // A press arriving together with a clear keeps the flag set so no event is lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_sticky <= '0;
        end else begin
            ev_sticky <= press_pulse | (ev_sticky & ~ev_clr);
        end
    end
`else
    logic unused_ev_clr;
    assign unused_ev_clr = ^ev_clr;
`endif

endmodule
